transceiver_arbiter: RTL

- Shares one outbound two-phase handshake channel (req/ack/data) between N router-side senders.
- Round-robin scheduling; one transfer in flight at a time.
- Sits between router output logic and a transceiver/link.
- Each sender sees a private two-phase channel; the link sees a single sender.

---
 rtl/transceiver_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/transceiver_arbiter.sv
// transceiver_arbiter
//   Shares one outbound two-phase (req/ack/data) link channel between N
//   router-side senders using round-robin scheduling, one transfer in flight.
//   Each sender sees a private two-phase channel; the link sees one sender.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   req_in    per-sender two-phase request (bit i = sender i)
//   ack_in    per-sender two-phase acknowledge
//   data_in   sender i data in bits [i*SIZE +: SIZE]
//   req_out   link two-phase request
//   ack_out   link two-phase acknowledge
//   data_out  link data, registered on the grant edge
//   busy      high while a transfer is in flight
//   grant     index of current/last granted sender
module transceiver_arbiter #(
  parameter int ID   = -1,
  parameter     PORT = "unknown",
  parameter int SIZE = 8,
  parameter int N    = 4,
  localparam int GW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_in,
  output logic [N-1:0]      ack_in,
  input  logic [N*SIZE-1:0] data_in,
  output logic              req_out,
  input  logic              ack_out,
  output logic [SIZE-1:0]   data_out,
  output logic              busy,
  output logic [GW-1:0]     grant
);

  // ID and PORT only label the instance for debug; this empty block keeps
  // them referenced in the elaborated design.
  if (ID < -1 && $bits(PORT) == 0) begin : g_diag_label
  end

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [N-1:0]      ack_q, ack_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     ptr_q, ptr_d;

  logic [N-1:0]      pending;
  logic              any_pending;
  logic [GW-1:0]     sel;

  assign pending     = req_in ^ ack_q;
  assign any_pending = |pending;

  // First pending sender scanning ptr, ptr+1, ..., wrapping modulo N.
  always_comb begin
    logic          found;
    int unsigned   idx;
    logic [GW-1:0] idx_g;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    idx_g = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      idx_g = GW'(idx);
      if (!found && pending[idx_g]) begin
        found = 1'b1;
        sel   = idx_g;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = ack_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        // ack_out is deliberately ignored here; a stray link toggle is only
        // seen once BUSY, where it completes that transfer immediately.
        if (any_pending) begin
          data_d  = data_in[sel*SIZE +: SIZE];
          req_d   = ~req_q;
          grant_d = sel;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (ack_out == req_q) begin
          ack_d[grant_q] = ~ack_q[grant_q];
          ptr_d          = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_out  = req_q;
  assign ack_in   = ack_q;
  assign data_out = data_q;
  assign grant    = grant_q;
  assign busy     = (state_q == S_BUSY);

endmodule
